// File: rtl/cpu_flags_pkg.sv
// Shared condition-flag types and bit positions for the producer and the branch decoder.
package cpu_flags_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam flags_t FLAGS_CLEAR = '{n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0};

endpackage

// File: rtl/zero_detect.sv
// Log-depth zero detector: the first stage NORs groups of ZFANIN input bits,
// every later stage ANDs groups of ZFANIN partial results down to one bit.
module zero_detect #(
  parameter int WIDTH  = 64,
  parameter int ZFANIN = 4
) (
  input  logic [WIDTH-1:0] data,
  output logic             z
);

  function automatic int lvl_nodes(input int l);
    int n;
    n = WIDTH;
    for (int k = 0; k < l; k++) n = (n + ZFANIN - 1) / ZFANIN;
    return n;
  endfunction

  function automatic int num_levels();
    int n;
    int l;
    n = WIDTH;
    l = 0;
    while (n > 1) begin
      n = (n + ZFANIN - 1) / ZFANIN;
      l++;
    end
    return l;
  endfunction

  localparam int LEVELS = num_levels();

  // Level 0 holds inverted inputs, so an AND over a group is the NOR of the raw bits.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = lvl_nodes(l);
    logic [N-1:0] nd;
    if (l == 0) begin : g_leaf
      assign nd = ~data;
    end else begin : g_stage
      localparam int NP = lvl_nodes(l - 1);
      for (genvar i = 0; i < N; i++) begin : g_node
        localparam int CNT = ((NP - i * ZFANIN) < ZFANIN) ? (NP - i * ZFANIN) : ZFANIN;
        assign nd[i] = &g_lvl[l-1].nd[i*ZFANIN +: CNT];
      end
    end
  end

  assign z = g_lvl[LEVELS].nd[0];

endmodule

// File: rtl/flag_register_unit.sv
// Condition-flag producer: derives N/Z/C/V from the ALU, registers them on ADDS/SUBS,
// and offers a same-cycle bypass to the branch decoder.
module flag_register_unit
  import cpu_flags_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int ZFANIN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_cmsb,
  input  logic             set_flags,
  input  logic             stall,
  input  logic             fwd_en,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             flags_valid,
  output logic             flags_upd
);

  logic   z_c;
  logic   we;
  flags_t c_flags;
  flags_t flags_q;
  flags_t out_flags;
  logic   valid_q;
  logic   upd_q;

  zero_detect #(
    .WIDTH  (WIDTH),
    .ZFANIN (ZFANIN)
  ) u_zero_detect (
    .data (alu_result),
    .z    (z_c)
  );

  assign we = set_flags & ~stall;

  always_comb begin
    c_flags   = FLAGS_CLEAR;
    c_flags.n = alu_result[WIDTH-1];
    c_flags.z = z_c;
    c_flags.c = alu_cout;
    c_flags.v = alu_cmsb ^ alu_cout;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= FLAGS_CLEAR;
      valid_q <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      if (we) begin
        flags_q <= c_flags;
        valid_q <= 1'b1;
      end
      upd_q <= we;
    end
  end

  // Reset gating is combinational so the bypass path is also silenced while reset is low.
  always_comb begin
    out_flags = flags_q;
    if (!reset) begin
      out_flags = FLAGS_CLEAR;
    end else if (fwd_en && we) begin
      out_flags = c_flags;
    end
  end

  assign negative    = out_flags[FLAG_N];
  assign zero        = out_flags[FLAG_Z];
  assign carry       = out_flags[FLAG_C];
  assign overflow    = out_flags[FLAG_V];
  assign flags_valid = valid_q;
  assign flags_upd   = upd_q;

endmodule

// File: tb/tb_flag_register_unit.sv
// Directed bench for flag_register_unit: a per-cycle vector table plus reset sequences.
module tb_flag_register_unit;

  localparam int WIDTH = 64;
  localparam logic [WIDTH-1:0] MSB_ONLY = 64'h8000_0000_0000_0000;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;
  logic             alu_cmsb;
  logic             set_flags;
  logic             stall;
  logic             fwd_en;
  logic             negative;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             flags_valid;
  logic             flags_upd;

  int checks;
  int failures;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             cmsb;
    logic             set;
    logic             stl;
    logic             fwd;
    logic [5:0]       exp;   // {N, Z, C, V, flags_valid, flags_upd} observed during the cycle
  } vec_t;

  vec_t vecs[$];

  flag_register_unit #(
    .WIDTH  (WIDTH),
    .ZFANIN (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_result  (alu_result),
    .alu_cout    (alu_cout),
    .alu_cmsb    (alu_cmsb),
    .set_flags   (set_flags),
    .stall       (stall),
    .fwd_en      (fwd_en),
    .negative    (negative),
    .zero        (zero),
    .carry       (carry),
    .overflow    (overflow),
    .flags_valid (flags_valid),
    .flags_upd   (flags_upd)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic drive(input logic [WIDTH-1:0] res, input logic co, input logic cm,
                       input logic sf, input logic st, input logic fe);
    alu_result = res;
    alu_cout   = co;
    alu_cmsb   = cm;
    set_flags  = sf;
    stall      = st;
    fwd_en     = fe;
  endtask

  task automatic add_vec(input logic [WIDTH-1:0] res, input logic co, input logic cm,
                         input logic sf, input logic st, input logic fe, input logic [5:0] e);
    vec_t v;
    v.res = res; v.cout = co; v.cmsb = cm; v.set = sf; v.stl = st; v.fwd = fe; v.exp = e;
    vecs.push_back(v);
  endtask

  function automatic logic [5:0] observed();
    return {negative, zero, carry, overflow, flags_valid, flags_upd};
  endfunction

  // Scoreboard compare
  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = observed();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b (NZCV,valid,upd)", name, act, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    //               result                  co    cm    set   stall fwd   NZCV_valid_upd
    add_vec(64'd5,                          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0000_00); // idle
    add_vec(MSB_ONLY,                       1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b0000_00); // ADDS max+1
    add_vec(64'd5,                          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b1001_11);
    add_vec(64'd5,                          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b1001_10); // pulse ends
    add_vec(64'd0,                          1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b1001_10); // SUBS x-x
    add_vec(64'd5,                          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0110_11);
    add_vec(64'd5,                          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0110_10); // held
    add_vec(MSB_ONLY,                       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0110_10); // N=1 write
    add_vec(64'd0,                          1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b1000_11); // stalled
    add_vec(64'd0,                          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b1000_10); // no pulse
    add_vec(64'd0,                          1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b0100_10); // bypass
    add_vec(MSB_ONLY,                       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b0100_11); // fwd, no we
    add_vec(MSB_ONLY,                       1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'b0100_10); // stall kills bypass
    add_vec(64'd1,                          1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0100_10); // back-to-back 1
    add_vec(MSB_ONLY,                       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0011_11); // back-to-back 2
    add_vec(64'd0,                          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b1000_11);
    add_vec(64'h0000_0001_0000_0000,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b0000_10); // mid bit set
    add_vec(64'hFFFF_FFFF_FFFF_FFFF,        1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'b1010_11); // all ones
    add_vec(64'd0,                          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b1010_11);

    // Reset held low: inputs toggle, bypass requested, nothing may show
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'b1, 1'b0, 1'b1);
      if (i == 2) alu_result = '0;
      #2;
      check($sformatf("reset_hold_%0d", i), 6'b0000_00);
    end
    @(negedge clk);
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    check("after_release", 6'b0000_00);

    // Table-driven vectors: drive at negedge, compare just before the next posedge
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].res, vecs[i].cout, vecs[i].cmsb, vecs[i].set, vecs[i].stl, vecs[i].fwd);
      #2;
      check($sformatf("vec_%0d", i), vecs[i].exp);
    end

    // Async reset mid-run: load N=1 C=1, then drop reset between edges
    @(negedge clk);
    drive(MSB_ONLY, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(64'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check("nc_loaded", 6'b1010_11);
    reset = 1'b0;
    #1;
    check("async_clear", 6'b0000_00);
    @(negedge clk);
    drive(64'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    #2;
    check("reset_low_bypass", 6'b0000_00);
    @(negedge clk);
    reset = 1'b1;
    drive(64'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    check("release_no_state", 6'b0000_00);
    @(negedge clk);
    drive(64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check("first_write_after_reset", 6'b0000_11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
